// File: rtl/instr_controller.sv
// ---------------------------------------------------------------------------
// instr_controller
//
// Purpose:
//   Control unit that owns the program counter and instruction register and
//   sequences fetch / decode / execute for the ProjectB datapath. It drives
//   the 16x16 register file (write enable, write address, both read
//   addresses), the data memory (address, write enable) and the ALU op.
//   Moore FSM: every control output depends only on state and IR.
//
// Ports:
//   clk        in   system clock, all state updates on posedge
//   resetN     in   synchronous active-low reset
//   instrData  in   instruction ROM data (ROM reads pcAddr combinationally)
//   pcAddr     out  current PC / ROM address
//   irOut      out  instruction register contents
//   dAddr      out  data memory address
//   dWrite     out  data memory write enable (gated by resetN)
//   rfSel      out  register-file write mux: 1 = data memory, 0 = ALU
//   rfWrAddr   out  register file write address
//   rfWriteEn  out  register file write enable (gated by resetN)
//   rfRdAddrA  out  register file A read address
//   rfRdAddrB  out  register file B read address
//   aluSel     out  ALU op: 00 pass A, 01 A+B, 10 A-B
//   stateOut   out  FSM state encoding for debug
//   halted     out  high while in HALT
//   illegalOp  out  sticky illegal-opcode flag (trap build only)
//
// Build option:
//   INSTR_CONTROLLER_TRAP_ILLEGAL_EN - when defined, opcodes 0110-1111 trap
//   into HALT and raise illegalOp; otherwise they execute as NOOP and
//   illegalOp is tied low.
// ---------------------------------------------------------------------------
module instr_controller #(
    parameter int PC_WIDTH        = 7,
    parameter int RF_ADDR_WIDTH   = 4,
    parameter int DMEM_ADDR_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic [15:0]                instrData,
    output logic [PC_WIDTH-1:0]        pcAddr,
    output logic [15:0]                irOut,
    output logic [DMEM_ADDR_WIDTH-1:0] dAddr,
    output logic                       dWrite,
    output logic                       rfSel,
    output logic [RF_ADDR_WIDTH-1:0]   rfWrAddr,
    output logic                       rfWriteEn,
    output logic [RF_ADDR_WIDTH-1:0]   rfRdAddrA,
    output logic [RF_ADDR_WIDTH-1:0]   rfRdAddrB,
    output logic [1:0]                 aluSel,
    output logic [3:0]                 stateOut,
    output logic                       halted,
    output logic                       illegalOp
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_LOAD_A = 4'd4,
        ST_LOAD_B = 4'd5,
        ST_STORE  = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    state_t                     r_state;
    state_t                     w_nextState;
    logic [PC_WIDTH-1:0]        r_pc;
    logic [15:0]                r_ir;
    logic [DMEM_ADDR_WIDTH-1:0] r_dAddr;
    logic                       r_dWrite;
    logic                       r_rfSel;
    logic [RF_ADDR_WIDTH-1:0]   r_rfWrAddr;
    logic                       r_rfWriteEn;
    logic [RF_ADDR_WIDTH-1:0]   r_rfRdAddrA;
    logic [RF_ADDR_WIDTH-1:0]   r_rfRdAddrB;
    logic [1:0]                 r_aluSel;
    logic                       r_halted;
    logic [3:0]                 w_opcode;

    assign w_opcode = r_ir[15:12];

    // Transition logic. IR is already loaded when DECODE is active, so the
    // opcode is taken from the register, not from the ROM bus.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_INIT:   w_nextState = ST_FETCH;
            ST_FETCH:  w_nextState = ST_DECODE;
            ST_DECODE: begin
                case (w_opcode)
                    4'd0:    w_nextState = ST_NOOP;
                    4'd1:    w_nextState = ST_STORE;
                    4'd2:    w_nextState = ST_LOAD_A;
                    4'd3:    w_nextState = ST_ADD;
                    4'd4:    w_nextState = ST_SUB;
                    4'd5:    w_nextState = ST_HALT;
`ifdef INSTR_CONTROLLER_TRAP_ILLEGAL_EN
                    default: w_nextState = ST_HALT;
`else
                    default: w_nextState = ST_NOOP;
`endif
                endcase
            end
            ST_LOAD_A: w_nextState = ST_LOAD_B;
            ST_HALT:   w_nextState = ST_HALT;
            default:   w_nextState = ST_FETCH;
        endcase
    end

    // State, PC/IR and registered Moore outputs. Outputs are computed from
    // the state being entered so they are valid for the whole cycle of that
    // state. The only edge where IR changes is FETCH->DECODE, and DECODE
    // drives no controls, so using the current IR here is always correct.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_state     <= ST_INIT;
            r_pc        <= '0;
            r_ir        <= '0;
            r_dAddr     <= '0;
            r_dWrite    <= 1'b0;
            r_rfSel     <= 1'b0;
            r_rfWrAddr  <= '0;
            r_rfWriteEn <= 1'b0;
            r_rfRdAddrA <= '0;
            r_rfRdAddrB <= '0;
            r_aluSel    <= 2'b00;
            r_halted    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (r_state == ST_FETCH) begin
                r_ir <= instrData;
                r_pc <= r_pc + PC_WIDTH'(1);
            end
            r_dAddr     <= '0;
            r_dWrite    <= 1'b0;
            r_rfSel     <= 1'b0;
            r_rfWrAddr  <= '0;
            r_rfWriteEn <= 1'b0;
            r_rfRdAddrA <= '0;
            r_rfRdAddrB <= '0;
            r_aluSel    <= 2'b00;
            r_halted    <= 1'b0;
            case (w_nextState)
                ST_LOAD_A: begin
                    r_dAddr <= DMEM_ADDR_WIDTH'(r_ir[11:4]);
                    r_rfSel <= 1'b1;
                end
                ST_LOAD_B: begin
                    r_dAddr     <= DMEM_ADDR_WIDTH'(r_ir[11:4]);
                    r_rfSel     <= 1'b1;
                    r_rfWrAddr  <= RF_ADDR_WIDTH'(r_ir[3:0]);
                    r_rfWriteEn <= 1'b1;
                end
                ST_STORE: begin
                    r_rfRdAddrA <= RF_ADDR_WIDTH'(r_ir[11:8]);
                    r_dAddr     <= DMEM_ADDR_WIDTH'(r_ir[7:0]);
                    r_dWrite    <= 1'b1;
                end
                ST_ADD, ST_SUB: begin
                    r_rfRdAddrA <= RF_ADDR_WIDTH'(r_ir[11:8]);
                    r_rfRdAddrB <= RF_ADDR_WIDTH'(r_ir[7:4]);
                    r_rfWrAddr  <= RF_ADDR_WIDTH'(r_ir[3:0]);
                    r_rfWriteEn <= 1'b1;
                    r_aluSel    <= (w_nextState == ST_ADD) ? 2'b01 : 2'b10;
                end
                ST_HALT: r_halted <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef INSTR_CONTROLLER_TRAP_ILLEGAL_EN
    logic r_illegalOp;

    // Sticky flag: set on the DECODE->HALT trap, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            r_illegalOp <= 1'b0;
        end else if (r_state == ST_DECODE && w_opcode > 4'd5) begin
            r_illegalOp <= 1'b1;
        end
    end

    assign illegalOp = r_illegalOp;
`else
    assign illegalOp = 1'b0;
`endif

    // Write strobes are masked by resetN directly so that a reset arriving
    // in the middle of a write cycle blocks the write in that same cycle.
    assign rfWriteEn = r_rfWriteEn & resetN;
    assign dWrite    = r_dWrite & resetN;

    assign pcAddr    = r_pc;
    assign irOut     = r_ir;
    assign dAddr     = r_dAddr;
    assign rfSel     = r_rfSel;
    assign rfWrAddr  = r_rfWrAddr;
    assign rfRdAddrA = r_rfRdAddrA;
    assign rfRdAddrB = r_rfRdAddrB;
    assign aluSel    = r_aluSel;
    assign stateOut  = r_state;
    assign halted    = r_halted;

endmodule

// File: tb/tb_instr_controller.sv
// ---------------------------------------------------------------------------
// tb_instr_controller
//
// Self-checking bench for instr_controller. A ROM array feeds instrData. An
// instruction-level model walks the program and, for every instruction,
// produces the expected output bundle of each cycle it occupies (fetch,
// decode, execute) from the ISA rules. Directed programs cover reset, LOAD,
// ADD/SUB, STORE, HALT, mid-LOAD reset and PC wrap with an illegal opcode;
// a randomized program of legal instructions follows.
// ---------------------------------------------------------------------------
module tb_instr_controller;

    logic        clk;
    logic        resetN;
    logic [15:0] instrData;
    logic [6:0]  pcAddr;
    logic [15:0] irOut;
    logic [7:0]  dAddr;
    logic        dWrite;
    logic        rfSel;
    logic [3:0]  rfWrAddr;
    logic        rfWriteEn;
    logic [3:0]  rfRdAddrA;
    logic [3:0]  rfRdAddrB;
    logic [1:0]  aluSel;
    logic [3:0]  stateOut;
    logic        halted;
    logic        illegalOp;

    logic [15:0] rom [128];

    int          testCount = 0;
    int          failCount = 0;

    logic [6:0]  mPc;
    logic [15:0] mIr;
    logic        mIll;

    instr_controller dut (
        .clk       (clk),
        .resetN    (resetN),
        .instrData (instrData),
        .pcAddr    (pcAddr),
        .irOut     (irOut),
        .dAddr     (dAddr),
        .dWrite    (dWrite),
        .rfSel     (rfSel),
        .rfWrAddr  (rfWrAddr),
        .rfWriteEn (rfWriteEn),
        .rfRdAddrA (rfRdAddrA),
        .rfRdAddrB (rfRdAddrB),
        .aluSel    (aluSel),
        .stateOut  (stateOut),
        .halted    (halted),
        .illegalOp (illegalOp)
    );

    // Asynchronous-read ROM addressed by the PC.
    assign instrData = rom[pcAddr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [53:0] packExp(
        input logic [3:0]  st,
        input logic [6:0]  pc,
        input logic [15:0] ir,
        input logic [7:0]  da,
        input logic        dw,
        input logic        rs,
        input logic [3:0]  wa,
        input logic        we,
        input logic [3:0]  ra,
        input logic [3:0]  rb,
        input logic [1:0]  alu,
        input logic        hl,
        input logic        il
    );
        return {st, pc, ir, da, dw, rs, wa, we, ra, rb, alu, hl, il};
    endfunction

    function automatic logic [53:0] observed();
        return {stateOut, pcAddr, irOut, dAddr, dWrite, rfSel, rfWrAddr,
                rfWriteEn, rfRdAddrA, rfRdAddrB, aluSel, halted, illegalOp};
    endfunction

    // Expected bundle for a state that drives no controls.
    function automatic logic [53:0] quietExp(input logic [3:0] st);
        return packExp(st, mPc, mIr, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0,
                       4'h0, 4'h0, 2'b00, 1'b0, 1'b0);
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [53:0] expVal);
        logic [53:0] obs;
        obs = observed();
        testCount++;
        assert (obs === expVal)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expVal);
        end
    endtask

    task automatic applyStimulus(input int addr, input logic [15:0] word);
        rom[addr] = word;
    endtask

    task automatic applyReset();
        resetN = 1'b0;
        cycle();
        cycle();
        mPc  = '0;
        mIr  = '0;
        mIll = 1'b0;
        checkOutput("reset_init", quietExp(4'd0));
        resetN = 1'b1;
        cycle();
    endtask

    // Walks one instruction starting in its FETCH cycle; leaves the bench
    // in the next FETCH cycle, or in the second HALT cycle for HALT/trap.
    task automatic runInstruction(input string tag);
        logic [15:0] w;
        w = rom[mPc];
        checkOutput({tag, "_fetch"}, quietExp(4'd1));
        mIr = w;
        mPc = mPc + 7'd1;
        cycle();
        checkOutput({tag, "_decode"}, quietExp(4'd2));
        cycle();
        case (w[15:12])
            4'd0: begin
                checkOutput({tag, "_noop"}, quietExp(4'd3));
                cycle();
            end
            4'd1: begin
                checkOutput({tag, "_store"}, packExp(4'd6, mPc, mIr, w[7:0],
                    1'b1, 1'b0, 4'h0, 1'b0, w[11:8], 4'h0, 2'b00, 1'b0, 1'b0));
                cycle();
            end
            4'd2: begin
                checkOutput({tag, "_loadA"}, packExp(4'd4, mPc, mIr, w[11:4],
                    1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0));
                cycle();
                checkOutput({tag, "_loadB"}, packExp(4'd5, mPc, mIr, w[11:4],
                    1'b0, 1'b1, w[3:0], 1'b1, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0));
                cycle();
            end
            4'd3, 4'd4: begin
                checkOutput({tag, "_alu"}, packExp(w[15:12] == 4'd3 ? 4'd7 : 4'd8,
                    mPc, mIr, 8'h00, 1'b0, 1'b0, w[3:0], 1'b1, w[11:8], w[7:4],
                    w[15:12] == 4'd3 ? 2'b01 : 2'b10, 1'b0, 1'b0));
                cycle();
            end
            4'd5: begin
                checkOutput({tag, "_halt"}, packExp(4'd9, mPc, mIr, 8'h00, 1'b0,
                    1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0));
                cycle();
            end
            default: begin
`ifdef INSTR_CONTROLLER_TRAP_ILLEGAL_EN
                mIll = 1'b1;
                checkOutput({tag, "_trap"}, packExp(4'd9, mPc, mIr, 8'h00, 1'b0,
                    1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1));
`else
                checkOutput({tag, "_illegalNoop"}, quietExp(4'd3));
`endif
                cycle();
            end
        endcase
    endtask

    initial begin
        resetN = 1'b0;
        for (int i = 0; i < 128; i++) applyStimulus(i, 16'h0000);

        // Directed program: LOAD, ADD, SUB, STORE, HALT.
        applyStimulus(0, 16'h2053);
        applyStimulus(1, 16'h3126);
        applyStimulus(2, 16'h4127);
        applyStimulus(3, 16'h1640);
        applyStimulus(4, 16'h5000);
        applyReset();
        runInstruction("load");
        runInstruction("add");
        runInstruction("sub");
        runInstruction("store");
        runInstruction("halt");
        for (int i = 0; i < 20; i++) begin
            checkOutput("halt_hold", packExp(4'd9, 7'd5, 16'h5000, 8'h00, 1'b0,
                1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0));
            cycle();
        end

        // Reset asserted during LOAD_B must suppress the write that cycle.
        applyReset();
        checkOutput("mid_fetch", quietExp(4'd1));
        mIr = 16'h2053;
        mPc = 7'd1;
        cycle();
        cycle();
        cycle();
        resetN = 1'b0;
        #1;
        checkOutput("mid_loadB_gated", packExp(4'd5, 7'd1, 16'h2053, 8'h05,
            1'b0, 1'b1, 4'h3, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0));
        cycle();
        mPc = '0;
        mIr = '0;
        checkOutput("mid_after_reset", quietExp(4'd0));

        // Randomized program of legal, non-halting instructions.
        for (int i = 0; i < 128; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 4));
            applyStimulus(i, w);
        end
        applyReset();
        for (int i = 0; i < 60; i++) runInstruction("rand");

        // PC wrap with an illegal opcode at the last ROM word.
        for (int i = 0; i < 127; i++) applyStimulus(i, 16'h0000);
        applyStimulus(127, 16'hF000);
        applyReset();
        for (int i = 0; i < 127; i++) runInstruction("wrap_noop");
        runInstruction("wrap_illegal");
`ifdef INSTR_CONTROLLER_TRAP_ILLEGAL_EN
        for (int i = 0; i < 5; i++) begin
            checkOutput("trap_hold", packExp(4'd9, 7'd0, 16'hF000, 8'h00, 1'b0,
                1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b1, 1'b1));
            cycle();
        end
`else
        checkOutput("wrap_pc0", packExp(4'd1, 7'd0, 16'hF000, 8'h00, 1'b0,
            1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0));
        runInstruction("after_wrap");
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/instr_controller.md
Name: instr_controller

Overview:
- Control-unit stage that sits directly upstream of the 16x16 register file in the ProjectB datapath.
- Owns the program counter (PC) and instruction register (IR), and sequences fetch/decode/execute.
- Drives the register file's write enable, write address and both read addresses, plus the data-memory and ALU controls.
- Moore FSM; one instruction completes every 3–4 clocks.

Parameters:
- PC_WIDTH, 7, instruction ROM address width; PC wraps modulo 2^PC_WIDTH.
- RF_ADDR_WIDTH, 4, register file address width.
- DMEM_ADDR_WIDTH, 8, data memory address width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- resetN  in  1  synchronous, active-low reset.
- instrData  in  16  instruction ROM read data; ROM reads pcAddr combinationally.
- pcAddr  out  PC_WIDTH  current PC, drives the ROM address.
- irOut  out  16  current instruction register contents.
- dAddr  out  DMEM_ADDR_WIDTH  data memory address.
- dWrite  out  1  data memory write enable.
- rfSel  out  1  register-file write-data mux select: 1 = data memory, 0 = ALU.
- rfWrAddr  out  RF_ADDR_WIDTH  register file write address.
- rfWriteEn  out  1  register file write enable.
- rfRdAddrA  out  RF_ADDR_WIDTH  register file A-side read address.
- rfRdAddrB  out  RF_ADDR_WIDTH  register file B-side read address.
- aluSel  out  2  ALU op: 00 = pass A, 01 = A+B, 10 = A-B.
- stateOut  out  4  current FSM state encoding, for debug.
- halted  out  1  high while in HALT.
- illegalOp  out  1  see Optional Feature.

Behaviour:
- Instruction encoding, opcode = IR[15:12]:
  - NOOP 0000.
  - STORE 0001: ra = IR[11:8], addr = IR[7:0].
  - LOAD 0010: addr = IR[11:4], rd = IR[3:0].
  - ADD 0011 / SUB 0100: ra = IR[11:8], rb = IR[7:4], rd = IR[3:0].
  - HALT 0101.
- States (encoding 0..9): INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT.
- Transitions:
  - INIT -> FETCH.
  - FETCH -> DECODE.
  - DECODE -> the state matching the opcode; opcodes 0110–1111 -> NOOP.
  - LOAD_A -> LOAD_B -> FETCH.
  - NOOP, STORE, ADD, SUB -> FETCH.
  - HALT -> HALT until reset.
- Reset (resetN sampled low at posedge):
  - state = INIT, PC = 0, IR = 0.
  - While in INIT, every output is 0 except stateOut = 0.
- FETCH: IR <= instrData and PC <= PC+1 at the same edge. PC wraps from 2^PC_WIDTH-1 to 0.
- Control outputs are decoded from state and IR only (Moore). Anything not listed below is 0.
  - LOAD_A: dAddr = IR[11:4], rfSel = 1.
  - LOAD_B: dAddr = IR[11:4], rfSel = 1, rfWrAddr = IR[3:0], rfWriteEn = 1.
  - STORE: rfRdAddrA = IR[11:8], dAddr = IR[7:0], dWrite = 1.
  - ADD: rfRdAddrA = IR[11:8], rfRdAddrB = IR[7:4], aluSel = 01, rfWrAddr = IR[3:0], rfWriteEn = 1.
  - SUB: same as ADD, but aluSel = 10.
  - HALT: halted = 1.
- Latency from the FETCH edge to retire:
  - NOOP / STORE / ADD / SUB / HALT: 3 cycles.
  - LOAD: 4 cycles.
- Write gating: rfWriteEn and dWrite are combinationally ANDed with resetN. No write reaches the register file or memory in any cycle where resetN is low, including a reset asserted mid-LOAD_B, STORE, ADD or SUB.
- R0 is an ordinary register; rd = 0 is written normally.
- The controller does no ALU width or overflow handling; that belongs to the ALU.

Optional Feature:
- Macro: INSTR_CONTROLLER_TRAP_ILLEGAL_EN.
- Defined:
  - DECODE on opcodes 0110–1111 -> HALT.
  - illegalOp is set at that transition and held high while halted; only reset clears it.
- Not defined:
  - Illegal opcodes execute as NOOP.
  - illegalOp is tied to 0.

Test Plan:
- Reset: hold resetN = 0 for 2 cycles, release -> pcAddr = 0, irOut = 0, stateOut = INIT, then FETCH on the next edge; rfWriteEn = dWrite = 0 throughout.
- LOAD: ROM[0] = 16'h2053 -> in LOAD_B (4th cycle after FETCH) rfWrAddr = 3, dAddr = 8'h05, rfSel = 1, rfWriteEn = 1; pcAddr = 1.
- ADD/SUB: ROM[1] = 16'h3126, ROM[2] = 16'h4127 -> rfRdAddrA = 1, rfRdAddrB = 2, aluSel = 01 with rfWrAddr = 6; then aluSel = 10 with rfWrAddr = 7; each takes 3 cycles.
- STORE then HALT: ROM[3] = 16'h1640, ROM[4] = 16'h5000 -> dWrite = 1, dAddr = 8'h40, rfRdAddrA = 6; then halted = 1 and pcAddr stays 5 for 20 cycles.
- Reset mid-op: drive resetN = 0 during the LOAD_B cycle -> rfWriteEn = 0 in that cycle; next state INIT, PC = 0.
- PC wrap + illegal opcode: fill the ROM with NOOPs plus 16'hF000 at address 127 -> PC wraps 127 -> 0 without the macro; with INSTR_CONTROLLER_TRAP_ILLEGAL_EN, halted = 1 and illegalOp = 1 after DECODE of 16'hF000.
